// File: rtl/tiny_ram_arbiter_if.sv
// ----------------------------------------------------------------------------
// tiny_ram_arbiter_if
// Request/response bundle between the two RAM requesters and tiny_ram_arbiter.
// Port 0 is the CPU load/store unit, port 1 the program loader / debug host.
//
// Handshake semantics (both ports): a command transfers on a rising clock edge
// where req_validN and req_readyN are both high. req_readyN may depend
// combinationally on req_validN; a requester may drop or change its command
// freely while it is not being accepted. Each accepted command produces
// exactly one rsp_validN pulse, one cycle wide, two cycles after acceptance.
// ----------------------------------------------------------------------------
interface tiny_ram_arbiter_if;

    // Port 0
    logic        req_valid0;
    logic        req_ready0;
    logic        req_we0;
    logic [31:0] req_addr0;
    logic [31:0] req_wdata0;
    logic        rsp_valid0;
    logic [31:0] rsp_rdata0;

    // Port 1
    logic        req_valid1;
    logic        req_ready1;
    logic        req_we1;
    logic [31:0] req_addr1;
    logic [31:0] req_wdata1;
    logic        rsp_valid1;
    logic [31:0] rsp_rdata1;

    // Arbiter status
    logic        busy;

    // Requester side
    modport master (
        output req_valid0, req_we0, req_addr0, req_wdata0,
        output req_valid1, req_we1, req_addr1, req_wdata1,
        input  req_ready0, rsp_valid0, rsp_rdata0,
        input  req_ready1, rsp_valid1, rsp_rdata1,
        input  busy
    );

    // Arbiter side
    modport slave (
        input  req_valid0, req_we0, req_addr0, req_wdata0,
        input  req_valid1, req_we1, req_addr1, req_wdata1,
        output req_ready0, rsp_valid0, rsp_rdata0,
        output req_ready1, rsp_valid1, rsp_rdata1,
        output busy
    );

endinterface

// File: rtl/tiny_ram_arbiter.sv
// ----------------------------------------------------------------------------
// tiny_ram_arbiter
// Owns a 2**ADDR_W x 32 single-port data RAM and shares it between two
// requesters. Each accepted command walks IDLE -> ACCESS -> RESP -> IDLE with
// no stalls: the RAM is touched in ACCESS, the response pulses in RESP.
//
// Arbitration when both ports are valid in IDLE:
//   default                     : round-robin, the port that did not win last
//   TINY_ARB_FIXED_PRIO_EN      : port 0 always wins (last grant still tracked)
//
// Reset is asynchronous and active high. It returns the FSM to IDLE, drops
// any in-flight access and leaves port 0 preferred; RAM contents survive.
// o_dbg_state / o_dbg_last_grant expose the FSM for observation only.
// ----------------------------------------------------------------------------
module tiny_ram_arbiter #(
    parameter int ADDR_W = 8
) (
    input  logic                CLK,
    input  logic                RST,
    tiny_ram_arbiter_if.slave   bus,
    output logic [1:0]          o_dbg_state,
    output logic                o_dbg_last_grant
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              r_state;
    logic                r_last_grant;
    logic                r_winner;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic                r_busy;
    logic                r_rsp_valid0;
    logic                r_rsp_valid1;
    logic [31:0]         r_rsp_rdata0;
    logic [31:0]         r_rsp_rdata1;
    logic [31:0]         r_mem [0:DEPTH-1];

    // ------------------------------------------------------------------
    // Combinational arbitration
    // ------------------------------------------------------------------
    logic                w_any_valid;
    logic                w_pick;        // 0 = port 0, 1 = port 1
    logic                w_grant_en;    // a handshake happens at the next edge
    logic                w_ready0;
    logic                w_ready1;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [31:0]         w_sel_wdata;
    logic                w_ram_we;

    // Upper address bits are deliberately ignored: addresses wrap at DEPTH.
    logic                w_unused_addr_bits;
    assign w_unused_addr_bits = &{1'b0, bus.req_addr0[31:ADDR_W], bus.req_addr1[31:ADDR_W]};

    // Pick a winner among valid ports and qualify ready with the IDLE state.
    always_comb begin
        w_any_valid = bus.req_valid0 | bus.req_valid1;
        w_pick      = 1'b0;
        if (bus.req_valid0 && bus.req_valid1) begin
`ifdef TINY_ARB_FIXED_PRIO_EN
            w_pick = 1'b0;
`else
            w_pick = ~r_last_grant;
`endif
        end else begin
            // Single requester wins; with none valid the choice is irrelevant.
            w_pick = ~bus.req_valid0;
        end
        // Ready is gated by RST so nothing looks accepted while held in reset.
        w_grant_en = (r_state == ST_IDLE) && !RST && w_any_valid;
        w_ready0   = w_grant_en && !w_pick;
        w_ready1   = w_grant_en &&  w_pick;
    end

    // Mux the winning port's command for latching at the handshake edge.
    always_comb begin
        w_sel_we    = bus.req_we0;
        w_sel_addr  = bus.req_addr0[ADDR_W-1:0];
        w_sel_wdata = bus.req_wdata0;
        if (w_pick) begin
            w_sel_we    = bus.req_we1;
            w_sel_addr  = bus.req_addr1[ADDR_W-1:0];
            w_sel_wdata = bus.req_wdata1;
        end
    end

    // The write fires only while in ACCESS; an async reset forces IDLE
    // immediately, so a reset before the ACCESS edge suppresses the write.
    assign w_ram_we = (r_state == ST_ACCESS) && r_we;

    // ------------------------------------------------------------------
    // Transaction FSM with registered response/busy outputs.
    // ------------------------------------------------------------------
    // Sequence one accepted command through ACCESS and RESP.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_winner     <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_busy       <= 1'b0;
            r_rsp_valid0 <= 1'b0;
            r_rsp_valid1 <= 1'b0;
            r_rsp_rdata0 <= '0;
            r_rsp_rdata1 <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_rsp_valid0 <= 1'b0;
                    r_rsp_valid1 <= 1'b0;
                    if (w_grant_en) begin
                        r_winner     <= w_pick;
                        r_last_grant <= w_pick;
                        r_we         <= w_sel_we;
                        r_addr       <= w_sel_addr;
                        r_wdata      <= w_sel_wdata;
                        r_busy       <= 1'b1;
                        r_state      <= ST_ACCESS;
                    end
                end

                ST_ACCESS: begin
                    // Capture read data (0 for a write ack) for the winner only;
                    // the other port's rdata keeps its last response.
                    if (r_winner) begin
                        r_rsp_valid1 <= 1'b1;
                        r_rsp_rdata1 <= r_we ? 32'd0 : r_mem[r_addr];
                    end else begin
                        r_rsp_valid0 <= 1'b1;
                        r_rsp_rdata0 <= r_we ? 32'd0 : r_mem[r_addr];
                    end
                    r_state <= ST_RESP;
                end

                ST_RESP: begin
                    r_rsp_valid0 <= 1'b0;
                    r_rsp_valid1 <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= ST_IDLE;
                end

                default: begin
                    r_rsp_valid0 <= 1'b0;
                    r_rsp_valid1 <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

    // RAM array write port; contents are intentionally not reset.
    always_ff @(posedge CLK) begin
        if (w_ram_we) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.req_ready0   = w_ready0;
    assign bus.req_ready1   = w_ready1;
    assign bus.rsp_valid0   = r_rsp_valid0;
    assign bus.rsp_valid1   = r_rsp_valid1;
    assign bus.rsp_rdata0   = r_rsp_rdata0;
    assign bus.rsp_rdata1   = r_rsp_rdata1;
    assign bus.busy         = r_busy;
    assign o_dbg_state      = r_state;
    assign o_dbg_last_grant = r_last_grant;

endmodule

// File: tb/tb_tiny_ram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_tiny_ram_arbiter
// Directed + random checks of tiny_ram_arbiter against a cycle-stamped model:
// each accepted command books its response two cycles later and frees the
// arbiter three cycles later; memory is a plain array.
// ----------------------------------------------------------------------------
module tb_tiny_ram_arbiter;

    // Clock / reset
    logic CLK = 1'b0;
    logic RST;
    logic [1:0] dbg_state;
    logic       dbg_last_grant;

    always #5 CLK = ~CLK;

    tiny_ram_arbiter_if bus();

    tiny_ram_arbiter #(.ADDR_W(8)) dut (
        .CLK              (CLK),
        .RST              (RST),
        .bus              (bus),
        .o_dbg_state      (dbg_state),
        .o_dbg_last_grant (dbg_last_grant)
    );

    // Scoreboard counters
    int n_checks = 0;
    int n_pass   = 0;

    // Reference model
    int          cyc       = 0;
    int          free_at   = 0;     // first cycle the arbiter may accept again
    int          resp_at   = -1;    // cycle in which a response must be visible
    int          resp_port = 0;
    logic [31:0] resp_data = '0;
    int          commit_at = -1;    // cycle after the ACCESS edge of a write
    logic [7:0]  commit_addr = '0;
    logic [31:0] commit_data = '0;
    logic        m_last_grant = 1'b1;
    logic [31:0] m_rdata [2];
    logic [31:0] m_mem [0:255];

    int grant_port_q[$];
    int grant_cyc_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h at cycle %0d", tag, obs, exp, cyc);
    endtask

    task automatic model_reset();
        free_at      = cyc;
        resp_at      = -1;
        commit_at    = -1;
        m_last_grant = 1'b1;
        m_rdata[0]   = '0;
        m_rdata[1]   = '0;
    endtask

    // Driver
    task automatic drive(input int p, input logic v, input logic we,
                         input logic [31:0] addr, input logic [31:0] data);
        if (p == 0) begin
            bus.req_valid0 = v; bus.req_we0 = we; bus.req_addr0 = addr; bus.req_wdata0 = data;
        end else begin
            bus.req_valid1 = v; bus.req_we1 = we; bus.req_addr1 = addr; bus.req_wdata1 = data;
        end
    endtask

    // One cycle: check outputs against the model, book any handshake, advance.
    task automatic tick();
        int win;
        logic [7:0] a;
        #1;
        win = -1;
        if (cyc >= free_at && !RST) begin
            if (bus.req_valid0 && bus.req_valid1) begin
`ifdef TINY_ARB_FIXED_PRIO_EN
                win = 0;
`else
                win = m_last_grant ? 0 : 1;
`endif
            end else if (bus.req_valid0) begin
                win = 0;
            end else if (bus.req_valid1) begin
                win = 1;
            end
        end
        if (resp_at == cyc) m_rdata[resp_port] = resp_data;

        chk("ready0", {31'd0, bus.req_ready0}, {31'd0, win == 0});
        chk("ready1", {31'd0, bus.req_ready1}, {31'd0, win == 1});
        chk("busy", {31'd0, bus.busy}, {31'd0, cyc < free_at});
        chk("rsp_valid0", {31'd0, bus.rsp_valid0}, {31'd0, resp_at == cyc && resp_port == 0});
        chk("rsp_valid1", {31'd0, bus.rsp_valid1}, {31'd0, resp_at == cyc && resp_port == 1});
        chk("rsp_rdata0", bus.rsp_rdata0, m_rdata[0]);
        chk("rsp_rdata1", bus.rsp_rdata1, m_rdata[1]);
        chk("ready_excl", {31'd0, bus.req_ready0 & bus.req_ready1}, 32'd0);
        chk("ready_busy", {31'd0, (bus.req_ready0 | bus.req_ready1) & bus.busy}, 32'd0);

        if (bus.req_ready0) begin grant_port_q.push_back(0); grant_cyc_q.push_back(cyc); end
        if (bus.req_ready1) begin grant_port_q.push_back(1); grant_cyc_q.push_back(cyc); end

        if (win >= 0) begin
            a = (win == 0) ? bus.req_addr0[7:0] : bus.req_addr1[7:0];
            if ((win == 0) ? bus.req_we0 : bus.req_we1) begin
                resp_data   = '0;
                commit_at   = cyc + 2;
                commit_addr = a;
                commit_data = (win == 0) ? bus.req_wdata0 : bus.req_wdata1;
            end else begin
                resp_data = m_mem[a];
            end
            resp_at      = cyc + 2;
            resp_port    = win;
            free_at      = cyc + 3;
            m_last_grant = win[0];
        end

        @(posedge CLK);
        cyc++;
        if (commit_at == cyc) begin
            m_mem[commit_addr] = commit_data;
            commit_at = -1;
        end
        @(negedge CLK);
    endtask

    // Single transaction from one port, then wait for its response to finish.
    task automatic txn(input int p, input logic we, input logic [31:0] addr, input logic [31:0] data);
        drive(p, 1'b1, we, addr, data);
        tick();
        drive(p, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        tick();
    endtask

    int exp_grants[4];
    logic [31:0] pre_val;

    initial begin
        RST = 1'b1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        model_reset();
        @(negedge CLK);

        // Reset then idle
        tick();
        tick();
        chk("rst_state", {30'd0, dbg_state}, 32'd0);
        chk("rst_last_grant", {31'd0, dbg_last_grant}, 32'd1);
        RST = 1'b0;
        for (int i = 0; i < 10; i++) tick();

        // Preload words 0..15 alternating ports
        for (int i = 0; i < 16; i++) txn(i % 2, 1'b1, i, $urandom);

        // Single write / read on port 0
        txn(0, 1'b1, 32'd7, 32'h0000_002A);
        chk("t2_wack", bus.rsp_rdata0, 32'd0);
        txn(0, 1'b0, 32'd7, 32'd0);
        chk("t2_read", bus.rsp_rdata0, 32'h0000_002A);

        // Cross-port coherence and address wrap
        txn(1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
        chk("t4_wack1", bus.rsp_rdata1, 32'd0);
        txn(0, 1'b0, 32'd0, 32'd0);
        chk("t4_wrap_read", bus.rsp_rdata0, 32'hDEAD_BEEF);

        // Contention from a fresh reset so port 0 is preferred
        RST = 1'b1;
        model_reset();
        tick();
        RST = 1'b0;
        tick();
        grant_port_q.delete();
        grant_cyc_q.delete();
        drive(0, 1'b1, 1'b0, 32'd1, 32'd0);
        drive(1, 1'b1, 1'b0, 32'd2, 32'd0);
        for (int i = 0; i < 12; i++) tick();
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 3; i++) tick();
`ifdef TINY_ARB_FIXED_PRIO_EN
        exp_grants = '{0, 0, 0, 0};
`else
        exp_grants = '{0, 1, 0, 1};
`endif
        chk("t3_grant_count", grant_port_q.size(), 32'd4);
        for (int i = 0; i < 4 && i < grant_port_q.size(); i++) begin
            chk("t3_grant_port", grant_port_q[i], exp_grants[i]);
            if (i > 0) chk("t3_grant_gap", grant_cyc_q[i] - grant_cyc_q[i-1], 32'd3);
        end

        // Reset during ACCESS drops the write and its response
        pre_val = m_mem[3];
        drive(0, 1'b1, 1'b1, 32'd3, 32'h0000_0055);
        tick();
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        RST = 1'b1;
        model_reset();
        tick();
        tick();
        RST = 1'b0;
        tick();
        tick();
        txn(0, 1'b0, 32'd3, 32'd0);
        chk("t5_preval", bus.rsp_rdata0, pre_val);

        // Random traffic on both ports; addresses alias into words 0..15
        for (int i = 0; i < 1000; i++) begin
            for (int p = 0; p < 2; p++) begin
                drive(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 15)), $urandom);
            end
            tick();
        end
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int i = 0; i < 4; i++) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
